// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: letter codes, timing multiples,
// FSM states and the letter-to-pattern table.
package morse_pkg;

  // Letter codes, identical to the decoder's output encoding
  localparam logic [4:0] CODE_SPACE = 5'd0;
  localparam logic [4:0] CODE_A = 5'd1,  CODE_B = 5'd2,  CODE_C = 5'd3,  CODE_D = 5'd4;
  localparam logic [4:0] CODE_E = 5'd5,  CODE_F = 5'd6,  CODE_G = 5'd7,  CODE_H = 5'd8;
  localparam logic [4:0] CODE_I = 5'd9,  CODE_J = 5'd10, CODE_K = 5'd11, CODE_L = 5'd12;
  localparam logic [4:0] CODE_M = 5'd13, CODE_N = 5'd14, CODE_O = 5'd15, CODE_P = 5'd16;
  localparam logic [4:0] CODE_Q = 5'd17, CODE_R = 5'd18, CODE_S = 5'd19, CODE_T = 5'd20;
  localparam logic [4:0] CODE_U = 5'd21, CODE_V = 5'd22, CODE_W = 5'd23, CODE_X = 5'd24;
  localparam logic [4:0] CODE_Y = 5'd25, CODE_Z = 5'd26;

  // Durations in Morse units. The timer takes a 2-bit unit count in which
  // 0 stands for four units, so WGAP_U truncates to 2'd0 on purpose.
  localparam int DOT_U  = 1;
  localparam int DASH_U = 3;
  localparam int EGAP_U = 1;
  localparam int CGAP_U = 3;
  localparam int WGAP_U = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CGAP,
    ST_WGAP,
    ST_BAD
  } morse_state_e;

  // bits holds the elements left-aligned: bits[3] is the first element, 1 = dash
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [3:0] bits;
  } morse_pat_t;

  function automatic morse_pat_t morse_pattern(input logic [4:0] code);
    morse_pat_t p;
    case (code)
      CODE_A:  p = {1'b1, 3'd2, 4'b0100};  // .-
      CODE_B:  p = {1'b1, 3'd4, 4'b1000};  // -...
      CODE_C:  p = {1'b1, 3'd4, 4'b1010};  // -.-.
      CODE_D:  p = {1'b1, 3'd3, 4'b1000};  // -..
      CODE_E:  p = {1'b1, 3'd1, 4'b0000};  // .
      CODE_F:  p = {1'b1, 3'd4, 4'b0010};  // ..-.
      CODE_G:  p = {1'b1, 3'd3, 4'b1100};  // --.
      CODE_H:  p = {1'b1, 3'd4, 4'b0000};  // ....
      CODE_I:  p = {1'b1, 3'd2, 4'b0000};  // ..
      CODE_J:  p = {1'b1, 3'd4, 4'b0111};  // .---
      CODE_K:  p = {1'b1, 3'd3, 4'b1010};  // -.-
      CODE_L:  p = {1'b1, 3'd4, 4'b0100};  // .-..
      CODE_M:  p = {1'b1, 3'd2, 4'b1100};  // --
      CODE_N:  p = {1'b1, 3'd2, 4'b1000};  // -.
      CODE_O:  p = {1'b1, 3'd3, 4'b1110};  // ---
      CODE_P:  p = {1'b1, 3'd4, 4'b0110};  // .--.
      CODE_Q:  p = {1'b1, 3'd4, 4'b1101};  // --.-
      CODE_R:  p = {1'b1, 3'd3, 4'b0100};  // .-.
      CODE_S:  p = {1'b1, 3'd3, 4'b0000};  // ...
      CODE_T:  p = {1'b1, 3'd1, 4'b1000};  // -
      CODE_U:  p = {1'b1, 3'd3, 4'b0010};  // ..-
      CODE_V:  p = {1'b1, 3'd4, 4'b0001};  // ...-
      CODE_W:  p = {1'b1, 3'd3, 4'b0110};  // .--
      CODE_X:  p = {1'b1, 3'd4, 4'b1001};  // -..-
      CODE_Y:  p = {1'b1, 3'd4, 4'b1011};  // -.--
      CODE_Z:  p = {1'b1, 3'd4, 4'b1100};  // --..
      default: p = {1'b0, 3'd0, 4'b0000};  // space and 27..31 carry no marks
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character-side handshake and key/element outputs of the Morse encoder.
// master = character source / key driver side, slave = the encoder.
interface morse_encoder_if;
  logic [4:0] LETTER;
  logic       LOAD;
  logic       READY;
  logic       KEY;
  logic       SHORT;
  logic       LONG;
  logic       END_CHAR;
  logic       ERR;

  modport master (
    output LETTER, LOAD,
    input  READY, KEY, SHORT, LONG, END_CHAR, ERR
  );

  modport slave (
    input  LETTER, LOAD,
    output READY, KEY, SHORT, LONG, END_CHAR, ERR
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Element timer: counts units*UNIT_CYCLES cycles from the edge on which
// start is high. done is high on the last cycle of the interval; done_nxt
// says the following cycle will be that last cycle, so the registered
// element pulses can line up with it. units == 0 means four units.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       RESET_N,
  input  logic       start,
  input  logic [1:0] units,
  output logic       done,
  output logic       done_nxt
);

  localparam int CNT_W = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [1:0]       rem_q, rem_d;
  logic             act_q, act_d;

  // Next count: restart on start, else step within the unit, then across units
  always_comb begin
    cyc_d = cyc_q;
    rem_d = rem_q;
    act_d = act_q;
    done  = act_q && (cyc_q == LAST_CYC) && (rem_q == 2'd0);
    if (start) begin
      cyc_d = '0;
      rem_d = units - 2'd1;
      act_d = 1'b1;
    end else if (act_q) begin
      if (done) begin
        act_d = 1'b0;
      end else if (cyc_q == LAST_CYC) begin
        cyc_d = '0;
        rem_d = rem_q - 2'd1;
      end else begin
        cyc_d = cyc_q + CNT_W'(1);
      end
    end
    done_nxt = act_d && (cyc_d == LAST_CYC) && (rem_d == 2'd0);
  end

  // Counter state
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc_q <= '0;
      rem_q <= 2'd0;
      act_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      rem_q <= rem_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse encoder top: accepts letter codes over LOAD/READY and keys them out
// on KEY with SHORT/LONG/END_CHAR pulses that feed the Morse decoder.
// Optional build macro: MORSE_WORD_GAP_EN turns code 0 into a 4-unit word gap
// instead of an error.
// Outputs are registered from the next-state values, so a change of state and
// the matching output change appear on the same clock edge.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 50000
) (
  input logic           Clk,
  input logic           RESET_N,
  morse_encoder_if.slave bus
);

  morse_state_e state_q, state_d;
  morse_pat_t   pat;
  logic         accept;
  logic         elem_nxt;
  logic [3:0]   sh_q;
  logic [2:0]   left_q;
  logic         tmr_start;
  logic [1:0]   tmr_units;
  logic         tmr_done;
  logic         tmr_done_nxt;
  logic         key_q, short_q, long_q, endc_q, err_q, ready_q;

  assign bus.READY    = ready_q;
  assign bus.KEY      = key_q;
  assign bus.SHORT    = short_q;
  assign bus.LONG     = long_q;
  assign bus.END_CHAR = endc_q;
  assign bus.ERR      = err_q;

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .Clk      (Clk),
    .RESET_N  (RESET_N),
    .start    (tmr_start),
    .units    (tmr_units),
    .done     (tmr_done),
    .done_nxt (tmr_done_nxt)
  );

  // Pattern lookup, handshake and the element about to be keyed
  always_comb begin
    pat    = morse_pattern(bus.LETTER);
    accept = bus.LOAD && ready_q;
    // From IDLE the first element comes straight from the table; otherwise the
    // shift register already holds the current/next element in its MSB.
    elem_nxt = (state_q == ST_IDLE) ? pat.bits[3] : sh_q[3];
  end

  // Next-state and timer control
  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_units = 2'(DOT_U);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (pat.valid) begin
            state_d   = ST_MARK;
            tmr_start = 1'b1;
            tmr_units = elem_nxt ? 2'(DASH_U) : 2'(DOT_U);
          end
`ifdef MORSE_WORD_GAP_EN
          else if (bus.LETTER == CODE_SPACE) begin
            state_d   = ST_WGAP;
            tmr_start = 1'b1;
            tmr_units = 2'(WGAP_U);
          end
`endif
          else begin
            state_d = ST_BAD;
          end
        end
      end
      ST_MARK: begin
        if (tmr_done) begin
          tmr_start = 1'b1;
          if (left_q > 3'd1) begin
            state_d   = ST_GAP;
            tmr_units = 2'(EGAP_U);
          end else begin
            state_d   = ST_CGAP;
            tmr_units = 2'(CGAP_U);
          end
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d   = ST_MARK;
          tmr_start = 1'b1;
          tmr_units = elem_nxt ? 2'(DASH_U) : 2'(DOT_U);
        end
      end
      ST_CGAP: begin
        if (tmr_done) state_d = ST_IDLE;
      end
`ifdef MORSE_WORD_GAP_EN
      ST_WGAP: begin
        if (tmr_done) state_d = ST_IDLE;
      end
`endif
      ST_BAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Pattern shift register: load on accept, advance when a mark finishes
  always_ff @(posedge Clk) begin
    if (accept) begin
      sh_q   <= pat.bits;
      left_q <= pat.len;
    end else if ((state_q == ST_MARK) && tmr_done && (left_q > 3'd1)) begin
      sh_q   <= {sh_q[2:0], 1'b0};
      left_q <= left_q - 3'd1;
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      key_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      endc_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      key_q   <= (state_d == ST_MARK);
      short_q <= (state_d == ST_MARK) && tmr_done_nxt && !elem_nxt;
      long_q  <= (state_d == ST_MARK) && tmr_done_nxt && elem_nxt;
      endc_q  <= (state_d == ST_CGAP) && tmr_done_nxt;
      err_q   <= (state_d == ST_BAD);
      ready_q <= (state_d == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: cycle-exact comparison against a dot/dash string
// model at UNIT_CYCLES=4, plus a second instance at UNIT_CYCLES=1 looped into
// a behavioural decoder.
module tb_morse_encoder;

  localparam int U = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  morse_encoder_if bus ();
  morse_encoder_if lb ();

  morse_encoder #(.UNIT_CYCLES(U)) dut (.Clk(clk), .RESET_N(rst_n), .bus(bus));
  morse_encoder #(.UNIT_CYCLES(1)) dut1 (.Clk(clk), .RESET_N(rst_n), .bus(lb));

  int n_vec = 0;
  int n_err = 0;

  // {READY, KEY, SHORT, LONG, END_CHAR, ERR} expected per clock period
  logic [5:0] exp_v [0:2047];

  function automatic string morse_of(input int code);
    case (code)
      1: return ".-";    2: return "-...";  3: return "-.-.";  4: return "-..";
      5: return ".";     6: return "..-.";  7: return "--.";   8: return "....";
      9: return "..";   10: return ".---"; 11: return "-.-";  12: return ".-..";
     13: return "--";   14: return "-.";   15: return "---";  16: return ".--.";
     17: return "--.-"; 18: return ".-.";  19: return "...";  20: return "-";
     21: return "..-";  22: return "...-"; 23: return ".--";  24: return "-..-";
     25: return "-.--"; 26: return "--..";
      default: return "";
    endcase
  endfunction

  function automatic logic [5:0] obs_main();
    return {bus.READY, bus.KEY, bus.SHORT, bus.LONG, bus.END_CHAR, bus.ERR};
  endfunction

  // Behavioural decoder on the loopback instance
  string lb_sym = "";
  int    lb_got[$];
  always @(negedge clk) begin
    if (lb.SHORT) lb_sym = {lb_sym, "."};
    if (lb.LONG)  lb_sym = {lb_sym, "-"};
    if (lb.END_CHAR) begin
      int code;
      code = 0;
      for (int i = 1; i <= 26; i++) if (morse_of(i) == lb_sym) code = i;
      lb_got.push_back(code);
      lb_sym = "";
    end
  end

  // Send codes with LOAD held; noise drives junk LETTER/LOAD while busy.
  // Must be called at a negedge with the DUT idle.
  task automatic run_letters(input string name, input int codes[$], input bit noise);
    int acc[$];
    int t, pp, idx, last_p;
    for (int i = 0; i < 2048; i++) exp_v[i] = 6'b100000;
    t = 0;
    foreach (codes[i]) begin
      string s;
      acc.push_back(t);
      s  = morse_of(codes[i]);
      pp = t + 1;
      if (s.len() > 0) begin
        for (int e = 0; e < s.len(); e++) begin
          bit dash;
          int ml, gl;
          dash = (s[e] == "-");
          ml = dash ? 3 * U : U;
          for (int k = 0; k < ml; k++) exp_v[pp + k][4] = 1'b1;
          if (dash) exp_v[pp + ml - 1][2] = 1'b1;
          else      exp_v[pp + ml - 1][3] = 1'b1;
          pp += ml;
          gl = (e == s.len() - 1) ? 3 * U : U;
          if (e == s.len() - 1) exp_v[pp + gl - 1][1] = 1'b1;
          pp += gl;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      else if (codes[i] == 0) pp += 4 * U;
`endif
      else begin
        exp_v[pp][0] = 1'b1;
        pp += 1;
      end
      for (int q = t + 1; q < pp; q++) exp_v[q][5] = 1'b0;
      t = pp;
    end
    last_p = t + 2;
    idx = 0;
    for (int p = 0; p <= last_p; p++) begin
      n_vec++;
      if (obs_main() !== exp_v[p]) begin
        n_err++;
        $display("FAIL %s period %0d: RDY/KEY/S/L/END/ERR got %b expected %b",
                 name, p, obs_main(), exp_v[p]);
      end
      if (idx < codes.size() && p == acc[idx]) begin
        bus.LETTER = 5'(codes[idx]);
        bus.LOAD   = 1'b1;
        idx++;
      end else if (noise && exp_v[p][5] == 1'b0) begin
        bus.LETTER = 5'($urandom);
        bus.LOAD   = 1'($urandom);
      end else begin
        bus.LETTER = 5'($urandom);
        bus.LOAD   = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.LOAD = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs_main() !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_main: got %b expected %b", obs_main(), 6'b100000);
    end
    n_vec++;
    if ({lb.READY, lb.KEY, lb.SHORT, lb.LONG, lb.END_CHAR, lb.ERR} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_loop: got %b expected %b",
               {lb.READY, lb.KEY, lb.SHORT, lb.LONG, lb.END_CHAR, lb.ERR}, 6'b100000);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_letter_e();
    run_letters("letter_E", '{5}, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_letters("A_then_T", '{1, 20}, 1'b0);
  endtask

  task automatic test_invalid();
    run_letters("invalid", '{27, 31, 0, 5}, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int q[$];
      int n;
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 31));
      run_letters($sformatf("random%0d", r), q, 1'b1);
    end
  endtask

  task automatic test_reset_mid_char();
    bus.LETTER = 5'd17;
    bus.LOAD   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.LOAD = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (bus.KEY !== 1'b1) begin
      n_err++;
      $display("FAIL Q_dash_key: got %b expected 1", bus.KEY);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_main() !== 6'b100000) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b", obs_main(), 6'b100000);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.END_CHAR !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_endchar: got %b expected 0", bus.END_CHAR);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_letters("E_after_reset", '{5}, 1'b0);
  endtask

  task automatic test_loopback();
    int sent, cyc;
    bit take;
    sent = 1;
    cyc  = 0;
    lb_got.delete();
    lb_sym = "";
    while (lb_got.size() < 26 && cyc < 2000) begin
      if (sent <= 26) begin
        lb.LETTER = 5'(sent);
        lb.LOAD   = 1'b1;
      end else begin
        lb.LOAD = 1'b0;
      end
      take = lb.LOAD && lb.READY;
      @(posedge clk);
      if (take) sent++;
      @(negedge clk);
      cyc++;
    end
    lb.LOAD = 1'b0;
    for (int i = 0; i < 26; i++) begin
      n_vec++;
      if (i >= lb_got.size()) begin
        n_err++;
        $display("FAIL loopback letter %0d: got nothing expected %0d", i + 1, i + 1);
      end else if (lb_got[i] !== i + 1) begin
        n_err++;
        $display("FAIL loopback letter %0d: got %0d expected %0d", i + 1, lb_got[i], i + 1);
      end
    end
  endtask

  initial begin
    bus.LETTER = 5'd0;
    bus.LOAD   = 1'b0;
    lb.LETTER  = 5'd0;
    lb.LOAD    = 1'b0;
    @(negedge clk);
    test_reset();
    test_letter_e();
    test_back_to_back();
    test_invalid();
    test_random();
    test_reset_mid_char();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
